// File: rtl/sefi_detector.sv
`default_nettype none
// ============================================================================
// Module   : sefi_detector
// Purpose  : Qualifies frame-ECC scrubber reports and the FPT core heartbeat
//            into a single registered SEFI flag for the Titan healer.
//            Tumbling CE window, UE trap, heartbeat watchdog, then a
//            post-flag hold-off so one upset yields exactly one recovery.
// Revision : 1.0 - initial release
// ============================================================================
module sefi_detector #(
  parameter int unsigned WINDOW_CYCLES = 600000,
  parameter int unsigned CE_THRESH     = 8,
  parameter int unsigned HB_TIMEOUT    = 4096,
  parameter int unsigned FLAG_HOLD     = 16,
  parameter int unsigned HOLDOFF       = 9000000
) (
  input  logic        clk_600mhz,
  input  logic        rst_n,
  input  logic        ecc_valid,
  input  logic        ecc_ce,
  input  logic        ecc_ue,
  input  logic        heartbeat,
  input  logic        hb_enable,
  output logic        sefi_flag,
  output logic [2:0]  sefi_cause,
  output logic [7:0]  ce_count,
  output logic [15:0] sefi_events
);

  localparam int unsigned WIN_W = $clog2(WINDOW_CYCLES + 1);
  localparam int unsigned HB_W  = $clog2(HB_TIMEOUT + 1);
  localparam int unsigned FH_W  = $clog2(FLAG_HOLD + 1);
  localparam int unsigned HO_W  = $clog2(HOLDOFF + 1);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(HB_TIMEOUT - 1);
  localparam logic [FH_W-1:0]  FH_LAST  = FH_W'(FLAG_HOLD - 1);
  localparam logic [HO_W-1:0]  HO_LAST  = HO_W'(HOLDOFF - 1);
  localparam logic [7:0]       CE_THR   = 8'(CE_THRESH);

  localparam logic [1:0] ST_MONITOR = 2'd0;
  localparam logic [1:0] ST_FLAG    = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;

  // Zero-valued or out-of-range parameters make the counters meaningless.
  generate
    if (WINDOW_CYCLES == 0 || CE_THRESH == 0 || CE_THRESH > 255 ||
        HB_TIMEOUT == 0 || FLAG_HOLD == 0 || HOLDOFF == 0) begin : g_param_check
      $error("sefi_detector: illegal parameter value");
    end
  endgenerate

  logic [1:0]       state;
  logic [WIN_W-1:0] win_cnt;
  logic [HB_W-1:0]  hb_timer;
  logic [FH_W-1:0]  flag_cnt;
  logic [HO_W-1:0]  hold_cnt;

  logic             win_wrap;
  logic             ce_in;
  logic [7:0]       ce_base;
  logic [7:0]       ce_next;
  logic [HB_W-1:0]  hb_age;
  logic [HB_W-1:0]  hb_next;
  logic             trig_ce;
  logic             trig_ue;
  logic             trig_hb;
  logic [2:0]       cause;

  // The wrap cycle starts the new window, so a CE on it counts from zero.
  assign win_wrap = (win_cnt == WIN_LAST);
  assign ce_in    = ecc_valid & ecc_ce;
  assign ce_base  = win_wrap ? 8'd0 : ce_count;
  assign ce_next  = (ce_in && ce_base != 8'hFF) ? ce_base + 8'd1 : ce_base;

  // A heartbeat makes the current cycle age 0; the register holds the age of
  // the following cycle, saturating at the timeout value.
  assign hb_age  = heartbeat ? '0 : hb_timer;
  assign hb_next = !hb_enable ? '0 :
                   (hb_age >= HB_LAST) ? HB_LAST : hb_age + 1'b1;

  assign trig_ce = (ce_next >= CE_THR);
  assign trig_ue = ecc_valid & ecc_ue;
  assign trig_hb = hb_enable & (hb_timer == HB_LAST) & ~heartbeat;
  assign cause   = {trig_hb, trig_ue, trig_ce};

  // Monitor / flag / hold-off sequencing with all status registers.
  always_ff @(posedge clk_600mhz) begin
    if (!rst_n) begin
      state       <= ST_MONITOR;
      win_cnt     <= '0;
      hb_timer    <= '0;
      flag_cnt    <= '0;
      hold_cnt    <= '0;
      ce_count    <= 8'd0;
      sefi_flag   <= 1'b0;
      sefi_cause  <= 3'b000;
      sefi_events <= 16'd0;
    end else begin
      case (state)
        ST_MONITOR: begin
          win_cnt  <= win_wrap ? '0 : win_cnt + 1'b1;
          ce_count <= ce_next;
          hb_timer <= hb_next;
          if (|cause) begin
            state      <= ST_FLAG;
            sefi_flag  <= 1'b1;
            sefi_cause <= cause;
            flag_cnt   <= '0;
            if (sefi_events != 16'hFFFF) begin
              sefi_events <= sefi_events + 16'd1;
            end
          end
        end
        ST_FLAG: begin
          // Monitoring is frozen while the flag is up; nothing is counted.
          if (flag_cnt == FH_LAST) begin
            state     <= ST_HOLDOFF;
            sefi_flag <= 1'b0;
            hold_cnt  <= '0;
            win_cnt   <= '0;
            ce_count  <= 8'd0;
            hb_timer  <= '0;
          end else begin
            flag_cnt <= flag_cnt + 1'b1;
          end
        end
        ST_HOLDOFF: begin
          win_cnt  <= '0;
          ce_count <= 8'd0;
          hb_timer <= '0;
          if (hold_cnt == HO_LAST) begin
            state <= ST_MONITOR;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_MONITOR;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sefi_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_sefi_detector
// Purpose  : Directed self-checking bench for sefi_detector with small
//            parameters (window 100, threshold 4, hb timeout 50, flag 16,
//            hold-off 200). Cycle 0 is the first cycle after reset release.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sefi_detector;

  logic        clk_600mhz = 1'b0;
  logic        rst_n      = 1'b0;
  logic        ecc_valid  = 1'b0;
  logic        ecc_ce     = 1'b0;
  logic        ecc_ue     = 1'b0;
  logic        heartbeat  = 1'b0;
  logic        hb_enable  = 1'b0;
  logic        sefi_flag;
  logic [2:0]  sefi_cause;
  logic [7:0]  ce_count;
  logic [15:0] sefi_events;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  sefi_detector #(
    .WINDOW_CYCLES (100),
    .CE_THRESH     (4),
    .HB_TIMEOUT    (50),
    .FLAG_HOLD     (16),
    .HOLDOFF       (200)
  ) dut (
    .clk_600mhz  (clk_600mhz),
    .rst_n       (rst_n),
    .ecc_valid   (ecc_valid),
    .ecc_ce      (ecc_ce),
    .ecc_ue      (ecc_ue),
    .heartbeat   (heartbeat),
    .hb_enable   (hb_enable),
    .sefi_flag   (sefi_flag),
    .sefi_cause  (sefi_cause),
    .ce_count    (ce_count),
    .sefi_events (sefi_events)
  );

  // Free-running clock.
  always #5 clk_600mhz = ~clk_600mhz;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  // Close the current cycle; afterwards the outputs belong to cycle cyc.
  task automatic tick();
    @(posedge clk_600mhz);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    ecc_valid = 1'b0;
    ecc_ce    = 1'b0;
    ecc_ue    = 1'b0;
    heartbeat = 1'b0;
    hb_enable = 1'b0;
    tick();
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic ue_pulse();
    ecc_valid = 1'b1; ecc_ue = 1'b1;
    tick();
    ecc_valid = 1'b0; ecc_ue = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_flag",   32'(sefi_flag),   32'd0);
    check("rst_cause",  32'(sefi_cause),  32'd0);
    check("rst_ce",     32'(ce_count),    32'd0);
    check("rst_events", 32'(sefi_events), 32'd0);

    // 1. CE burst in cycles 10..13
    run_to(10);
    ecc_valid = 1'b1; ecc_ce = 1'b1;
    tick();
    check("ce_cnt1", 32'(ce_count), 32'd1);
    run_to(13);
    check("ce_cnt3",     32'(ce_count),  32'd3);
    check("ce_noflag13", 32'(sefi_flag), 32'd0);
    tick();
    ecc_valid = 1'b0; ecc_ce = 1'b0;
    check("ce_flag14",   32'(sefi_flag),   32'd1);
    check("ce_cause",    32'(sefi_cause),  32'b001);
    check("ce_events",   32'(sefi_events), 32'd1);
    run_to(29);
    check("ce_flag29",   32'(sefi_flag),   32'd1);
    tick();
    check("ce_flag30",   32'(sefi_flag),   32'd0);
    check("ce_hold_cnt", 32'(ce_count),    32'd0);
    check("ce_cause_kept", 32'(sefi_cause), 32'b001);

    // 2. Window wrap: 3 CEs at 96..98, one on the wrap cycle 99
    do_reset();
    run_to(96);
    ecc_valid = 1'b1; ecc_ce = 1'b1;
    run_to(99);
    check("wrap_cnt3", 32'(ce_count), 32'd3);
    tick();
    ecc_valid = 1'b0; ecc_ce = 1'b0;
    check("wrap_cnt1",   32'(ce_count),    32'd1);
    check("wrap_noflag", 32'(sefi_flag),   32'd0);
    check("wrap_events", 32'(sefi_events), 32'd0);

    // 3. UE at 49 coincides with heartbeat timeout (last heartbeat at 0)
    do_reset();
    hb_enable = 1'b1;
    heartbeat = 1'b1;
    tick();
    heartbeat = 1'b0;
    run_to(49);
    check("ue_hb_noflag49", 32'(sefi_flag), 32'd0);
    ue_pulse();
    check("ue_hb_flag50", 32'(sefi_flag),   32'd1);
    check("ue_hb_cause",  32'(sefi_cause),  32'b110);
    check("ue_hb_events", 32'(sefi_events), 32'd1);

    // 4. Heartbeat on the timeout cycle 49 wins; watchdog restarts
    do_reset();
    hb_enable = 1'b1;
    run_to(49);
    heartbeat = 1'b1;
    tick();
    heartbeat = 1'b0;
    check("hbwin_noflag", 32'(sefi_flag),   32'd0);
    check("hbwin_events", 32'(sefi_events), 32'd0);
    run_to(98);
    check("hbwin_noflag98", 32'(sefi_flag), 32'd0);
    tick();
    check("hb_restart_flag",  32'(sefi_flag),  32'd1);
    check("hb_restart_cause", 32'(sefi_cause), 32'b100);

    // 5. Hold-off blanking
    do_reset();
    run_to(10);
    ue_pulse();
    check("ho_flag11", 32'(sefi_flag), 32'd1);
    run_to(26);
    check("ho_flag26", 32'(sefi_flag), 32'd1);
    tick();
    check("ho_flag27", 32'(sefi_flag), 32'd0);
    run_to(30);
    ue_pulse();
    run_to(220);
    ue_pulse();
    check("ho_blank_flag",   32'(sefi_flag),   32'd0);
    check("ho_blank_events", 32'(sefi_events), 32'd1);
    run_to(227);
    check("ho_noflag227", 32'(sefi_flag), 32'd0);
    ue_pulse();
    check("ho_flag228",   32'(sefi_flag),   32'd1);
    check("ho_events2",   32'(sefi_events), 32'd2);

    // 6. Reset on the 5th flag cycle
    do_reset();
    run_to(10);
    ue_pulse();
    check("rf_flag11", 32'(sefi_flag), 32'd1);
    run_to(15);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rf_flag",   32'(sefi_flag),   32'd0);
    check("rf_cause",  32'(sefi_cause),  32'd0);
    check("rf_events", 32'(sefi_events), 32'd0);
    check("rf_ce",     32'(ce_count),    32'd0);
    ue_pulse();
    check("rf_new_flag",   32'(sefi_flag),   32'd1);
    check("rf_new_cause",  32'(sefi_cause),  32'b010);
    check("rf_new_events", 32'(sefi_events), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sefi_detector.md
# sefi_detector

Upstream stage of the Titan healer: turns raw frame-ECC scrubber reports and the FPT core heartbeat into a single qualified `sefi_flag` level. The flag launches veto and DPR in the healer. The block runs a tumbling correctable-error window, an uncorrectable-error trap and a heartbeat watchdog. After each flag it enforces a hold-off that covers the 15 ms DPR so that one upset produces exactly one recovery.

## Interface
- `WINDOW_CYCLES`, 600000: tumbling CE window length (1 ms at 600 MHz).
- `CE_THRESH`, 8: number of CEs in one window that triggers a flag; range 1..255.
- `HB_TIMEOUT`, 4096: heartbeat silence, in cycles, that triggers a flag.
- `FLAG_HOLD`, 16: cycles `sefi_flag` stays high per event.
- `HOLDOFF`, 9000000: post-flag blanking in cycles (15 ms DPR).
- `clk_600mhz` in 1: sole clock; all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `ecc_valid` in 1: one scrubber frame result this cycle.
- `ecc_ce` in 1: correctable error; qualified by `ecc_valid`.
- `ecc_ue` in 1: uncorrectable error; qualified by `ecc_valid`.
- `heartbeat` in 1: FPT core liveness strobe.
- `hb_enable` in 1: arms the watchdog.
- `sefi_flag` out 1: registered SEFI level, consumed by the healer.
- `sefi_cause` out 3: `{hb, ue, ce_burst}`, latched at each trigger.
- `ce_count` out 8: saturating CE count in the current window.
- `sefi_events` out 16: saturating total trigger count.

## Operation
- **States.** MONITOR, FLAG, HOLDOFF.
  - Reset puts the block in MONITOR.
  - Reset values: all outputs 0, all counters 0.
- **MONITOR.**
  - The window counter runs 0..WINDOW_CYCLES-1 and then wraps.
  - At the wrap cycle, `ce_count` clears. A CE arriving on the wrap cycle counts into the new window, giving `ce_count`=1.
  - `ce_count` saturates at 255.
- **Trigger conditions**, evaluated every MONITOR cycle:
  - ue = `ecc_valid & ecc_ue`.
  - ce_burst = post-increment `ce_count` ≥ CE_THRESH.
  - hb = `hb_enable` & (hb timer == HB_TIMEOUT-1) & !`heartbeat`.
- **On any trigger:**
  - Next state is FLAG.
  - `sefi_cause` is loaded with the OR of all conditions true that cycle.
  - `sefi_events` increments, saturating at 0xFFFF.
- **Simultaneous and edge cases:**
  - `ecc_ce` and `ecc_ue` in the same report: ue fires, and the CE is still counted.
  - Several conditions in the same cycle: one event, multiple cause bits set.
- **Heartbeat watchdog:**
  - A `heartbeat` pulse zeroes the hb timer. A heartbeat on the timeout cycle wins, so no trigger.
  - While `hb_enable` is low, the timer is held at 0.
  - The timer saturates; it does not wrap.
- **FLAG.**
  - `sefi_flag` is high for exactly FLAG_HOLD cycles, then the state moves to HOLDOFF.
  - New triggers are ignored and not counted.
- **HOLDOFF.**
  - Lasts HOLDOFF cycles with `sefi_flag` low.
  - Window counter, `ce_count` and hb timer are held at 0.
  - ECC reports and triggers are discarded.
  - On exit, the state returns to MONITOR with a fresh window starting at count 0.
- **Status outputs.**
  - `sefi_cause` holds until the next trigger or reset.
  - `ce_count` and `sefi_events` are free-running status.
- **Width rules.**
  - Each counter width is `$clog2(param+1)`.
  - All comparisons are unsigned.
  - Parameters of 0 are illegal; a simulation assertion checks this at elaboration.

## Timing
- Trigger inputs sampled at cycle N cause `sefi_flag`=1 in cycle N+1, together with the updated `sefi_cause` and `sefi_events`.
- `sefi_flag` is high during cycles N+1..N+FLAG_HOLD and low from N+FLAG_HOLD+1.
- The earliest next trigger is sampled at cycle N+FLAG_HOLD+HOLDOFF+1, with its flag one cycle later.
- `ce_count` updates the cycle after the qualifying report.
- **Reset mid-operation:** `rst_n` low sampled at cycle M gives all outputs 0 and state MONITOR in cycle M+1, including mid-FLAG and mid-HOLDOFF. A flag is never extended across reset.
- There is no handshake with the healer; `sefi_flag` is a pure registered level with no combinational path from the inputs.

## Test plan
Simulation parameters: WINDOW_CYCLES=100, CE_THRESH=4, HB_TIMEOUT=50, FLAG_HOLD=16, HOLDOFF=200.

1. **CE burst.** With `hb_enable`=0, send 4 CE reports in cycles 10..13 → `sefi_flag` rises at 14 and falls at 30; `sefi_cause`=3'b001; `sefi_events`=1.
2. **Window wrap.** Send 3 CEs late in window 0, then a CE on the wrap cycle → no flag; `ce_count`=1 afterwards.
3. **UE plus heartbeat timeout.** With `hb_enable`=1, the last heartbeat at cycle 0 and an `ecc_ue` report at cycle 49 → a single flag at 50; `sefi_cause`=3'b110; `sefi_events`=1.
4. **Heartbeat wins.** A heartbeat exactly on the timeout cycle → no flag; the timer restarts at 0.
5. **Hold-off blanking.** A UE at cycle 10, then further UEs at 30 and 220 → one flag only; `sefi_events`=1. A UE at 227 → flag at 228; `sefi_events`=2.
6. **Reset during FLAG.** Assert `rst_n`=0 at the 5th flag cycle for 1 cycle → next cycle all outputs 0; a fresh UE triggers one cycle later.
